gpr_file: RTL and testbench
===========================

# gpr_file

32 × 32-bit general-purpose register file for the pipelined CPU: one write port driven by write-back, two combinational read ports for decode, and a debug dump sequencer that streams all registers out one per cycle. Writes land on the falling clock edge, the same convention as the PC and pipeline storage cells. A write-back in the first half of a cycle is therefore readable by decode in the second half of that cycle, and no write-to-read bypass is needed.

## Interface
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register index width; 2^ADDR_W registers
- `clk_sig`  in  1  clock
- `rst_sig`  in  1  reset, asynchronous, active-high
- `wr_en`  in  1  write enable, sampled on negedge `clk_sig`
- `wr_addr`  in  ADDR_W  write index
- `wr_data`  in  DATA_W  write data
- `rd_addr_a`  in  ADDR_W  read port A index
- `rd_data_a`  out  DATA_W  read port A data, combinational
- `rd_addr_b`  in  ADDR_W  read port B index
- `rd_data_b`  out  DATA_W  read port B data, combinational
- `dump_req`  in  1  start a full-register dump, sampled on posedge
- `dump_busy`  out  1  dump in progress
- `dump_valid`  out  1  `dump_addr`/`dump_data` valid this cycle
- `dump_addr`  out  ADDR_W  index being dumped
- `dump_data`  out  DATA_W  contents of `dump_addr`
- `dump_done`  out  1  one-cycle pulse after the last word

## Operation
**Storage**
- All registers clear to 0 while `rst_sig` is high, asynchronously.
- On negedge with `rst_sig`=0 and `wr_en`=1, `wr_data` is written to `wr_addr`, except when `wr_addr`=0.
- Register 0 always reads 0. A write to it is discarded.

**Read ports**
- `rd_data_x` = array[`rd_addr_x`]. Reads are purely combinational. Both ports may use the same address.

**Dump FSM** (posedge, async reset to IDLE)
- IDLE: when `dump_req`=1, go to DUMP with index=0.
- DUMP: each cycle assert `dump_valid` and output index and array[index], registered. Increment the index. After index 2^ADDR_W−1, go to DONE.
- DONE: pulse `dump_done` for one cycle, then return to IDLE.
- `dump_req` in DUMP or DONE is ignored; there is no queuing.
- The dump reads the live array. A write completed at the negedge before a given posedge is reflected in that posedge's sample.

## Timing
**Reset values**
- `dump_busy`, `dump_valid`, `dump_done` = 0.
- `dump_addr`, `dump_data` = 0.
- `rd_data_a`, `rd_data_b` = 0, because the array is cleared.

**Write and read**
- Write latency: data is visible on the read ports immediately after the writing negedge, in the same cycle.
- If `rst_sig` is high at a negedge, no write occurs. Reset wins over `wr_en`.

**Dump sequencing**
- `dump_req` high at posedge N gives `dump_busy`=1 from N.
- The first `dump_valid` (addr 0) appears at N+1 and the last (addr 31) at N+32.
- `dump_done`=1 at N+33. `dump_busy` falls at N+34.
- Total occupancy: 34 cycles.
- The index wraps at 2^ADDR_W. It must not overflow into a 33rd beat.

**Reset mid-dump**
- Asserting `rst_sig` mid-dump immediately forces IDLE, clears all dump outputs, and clears the array.

## Structure
- Shared package `gpr_pkg`: `DATA_W`, `ADDR_W`, `REG_COUNT` = 2^ADDR_W, `ZERO_REG` = 0, dump state enum {IDLE, DUMP, DONE}.
- One sub-module: `gpr_read_port`, a combinational index-to-data mux with the zero-register rule. It is instantiated for port A, port B, and the dump sampler.

## Test plan
- Reset then read all 32 indices on both ports: every value is 0x00000000.
- Write 0xDEADBEEF to r5 at a negedge, with `rd_addr_a`=5 in the same cycle: `rd_data_a`=0xDEADBEEF before the next posedge.
- Write 0x12345678 to r0, then read r0 on both ports: result is 0.
- Write r1..r31 with values 0x100+i, then pulse `dump_req`:
  - 32 consecutive `dump_valid` beats with addr 0..31 and data 0, 0x101..0x11F;
  - `dump_done` exactly one cycle after addr 31;
  - a second `dump_req` during the dump is ignored.
- Mid-dump (addr 10), write r20=0xCAFEF00D: the addr-20 beat shows 0xCAFEF00D.
- Assert `rst_sig` at dump beat 7 while `wr_en`=1:
  - `dump_busy`/`dump_valid` drop immediately;
  - r3 written earlier reads 0;
  - a new `dump_req` after reset starts from addr 0.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared constants and types for the general-purpose register file.
package gpr_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DUMP,
    DONE
  } dump_state_e;

endpackage

// File: rtl/gpr_read_port.sv
// Combinational index-to-data mux; index 0 is hardwired to zero.
module gpr_read_port
  import gpr_pkg::*;
(
  input  logic [DATA_W-1:0] regs_i [REG_COUNT],
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  assign data_o = (addr_i == ZERO_REG) ? '0 : regs_i[addr_i];

endmodule

// File: rtl/gpr_file.sv
// 32x32 register file: negedge write port, two async read ports,
// and a posedge dump sequencer streaming every register once.
module gpr_file
  import gpr_pkg::*;
(
  input  logic              clk_sig,
  input  logic              rst_sig,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];

  dump_state_e       state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              busy_q;
  logic              valid_q;
  logic              done_q;
  logic [ADDR_W-1:0] daddr_q;
  logic [DATA_W-1:0] ddata_q;
  logic [DATA_W-1:0] samp_data;

  // Falling-edge write lets decode see write-back in the same cycle.
  always_ff @(negedge clk_sig or posedge rst_sig) begin
    if (rst_sig) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en && (wr_addr != ZERO_REG)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  gpr_read_port u_port_a (
    .regs_i (regs_q),
    .addr_i (rd_addr_a),
    .data_o (rd_data_a)
  );

  gpr_read_port u_port_b (
    .regs_i (regs_q),
    .addr_i (rd_addr_b),
    .data_o (rd_data_b)
  );

  gpr_read_port u_port_dump (
    .regs_i (regs_q),
    .addr_i (idx_q),
    .data_o (samp_data)
  );

  always_ff @(posedge clk_sig or posedge rst_sig) begin
    if (rst_sig) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      daddr_q <= '0;
      ddata_q <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy_q <= dump_req;
          if (dump_req) begin
            state_q <= DUMP;
            idx_q   <= '0;
          end
        end
        DUMP: begin
          valid_q <= 1'b1;
          daddr_q <= idx_q;
          ddata_q <= samp_data;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dump_busy  = busy_q;
  assign dump_valid = valid_q;
  assign dump_addr  = daddr_q;
  assign dump_data  = ddata_q;
  assign dump_done  = done_q;

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: read/write ports and dump stream.
module tb_gpr_file;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_b;
  logic        dump_req;
  logic        dump_busy;
  logic        dump_valid;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_done;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  logic        expect_done = 1'b0;
  logic [31:0] model [32];
  logic [36:0] exp_q [$];

  gpr_file dut (
    .clk_sig    (clk),
    .rst_sig    (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr_a  (rd_addr_a),
    .rd_data_a  (rd_data_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (rd_data_b),
    .dump_req   (dump_req),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  // Scoreboard side: compare each dump beat, and the done pulse.
  always @(negedge clk) begin
    if (rst) begin
      expect_done = 1'b0;
    end else begin
      chk("dump_done", {31'd0, dump_done}, {31'd0, expect_done});
      expect_done = dump_valid && (dump_addr == 5'd31);
      if (dump_valid) begin
        beats++;
        if (exp_q.size() == 0) begin
          chk("dump_extra_beat", 32'd1, 32'd0);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          chk("dump_addr", {27'd0, dump_addr}, {27'd0, e[36:32]});
          chk("dump_data", dump_data, e[31:0]);
        end
      end
    end
  end

  task automatic push_dump();
    beats = 0;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back({5'(i), model[i]});
    end
  endtask

  task automatic request();
    @(posedge clk); #1;
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    chk("busy_start", {31'd0, dump_busy}, 32'd1);
  endtask

  task automatic wait_beat(input logic [4:0] a);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(posedge clk); #1;
      hit = dump_valid && (dump_addr == a);
    end
    if (!hit) chk("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(output int lat);
    logic hit;
    hit = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40 && !hit; k++) begin
      @(posedge clk); #1;
      if (dump_done) begin
        hit = 1'b1;
        lat = k;
      end
    end
    if (!hit) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk); #1;
    wr_en = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    dump_req  = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    #1;
    chk("rst_busy", {31'd0, dump_busy}, 32'd0);
    chk("rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("rst_done", {31'd0, dump_done}, 32'd0);
    chk("rst_daddr", {27'd0, dump_addr}, 32'd0);
    chk("rst_ddata", dump_data, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      #1;
      chk("rst_rd_a", rd_data_a, 32'd0);
      chk("rst_rd_b", rd_data_b, 32'd0);
    end

    // Same-cycle visibility: check right after the writing negedge.
    rd_addr_a = 5'd5;
    write_reg(5'd5, 32'hDEADBEEF);
    chk("wr_same_cycle", rd_data_a, 32'hDEADBEEF);

    write_reg(5'd0, 32'h12345678);
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd0;
    #1;
    chk("r0_a", rd_data_a, 32'd0);
    chk("r0_b", rd_data_b, 32'd0);

    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'h100 + 32'(i));
    end
    rd_addr_a = 5'd17;
    rd_addr_b = 5'd17;
    #1;
    chk("same_addr_a", rd_data_a, 32'h111);
    chk("same_addr_b", rd_data_b, 32'h111);

    // Full dump with a stray request mid-stream.
    push_dump();
    request();
    lat = 0;
    begin
      logic hit;
      hit = 1'b0;
      for (int k = 1; k <= 40 && !hit; k++) begin
        @(posedge clk); #1;
        dump_req = (k == 15);
        if (dump_done) begin
          hit = 1'b1;
          lat = k;
        end
      end
      dump_req = 1'b0;
      if (!hit) chk("done_timeout", 32'd0, 32'd1);
    end
    chk("done_latency", 32'(lat), 32'd33);
    chk("busy_at_done", {31'd0, dump_busy}, 32'd1);
    @(posedge clk); #1;
    chk("busy_fall", {31'd0, dump_busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("no_requeue", {31'd0, dump_busy}, 32'd0);
    chk("beats_1", 32'(beats), 32'd32);
    chk("queue_1", 32'(exp_q.size()), 32'd0);

    // Live array: write r20 while the stream is at addr 10.
    model[20] = 32'hCAFEF00D;
    push_dump();
    request();
    wait_beat(5'd10);
    wr_en   = 1'b1;
    wr_addr = 5'd20;
    wr_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    wr_en = 1'b0;
    wait_done(lat);
    @(posedge clk); #1;
    chk("beats_2", 32'(beats), 32'd32);
    chk("queue_2", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a dump while a write is pending.
    push_dump();
    request();
    wait_beat(5'd7);
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h99999999;
    rst     = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, dump_busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("mid_rst_daddr", {27'd0, dump_addr}, 32'd0);
    chk("mid_rst_ddata", dump_data, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 32; i++) model[i] = '0;
    @(negedge clk); #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_addr_a = 5'd3;
    rd_addr_b = 5'd9;
    #1;
    chk("r3_cleared", rd_data_a, 32'd0);
    chk("r9_no_write", rd_data_b, 32'd0);

    push_dump();
    request();
    wait_done(lat);
    @(posedge clk); #1;
    chk("beats_3", 32'(beats), 32'd32);
    chk("queue_3", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
